// File: rtl/wb_conbus_rr.sv
// ---------------------------------------------------------------------------
// wb_conbus_rr
//   Parametrised Wishbone shared-bus interconnect. NUM_M masters share one
//   bus to NUM_S slaves. Slaves are selected by decoding the top S_ADDR_W
//   address bits against a packed map. Ownership is granted round-robin and
//   held for a whole Wishbone cycle (while the owner keeps cyc high).
//   Unmapped accesses and a stalled-ack watchdog both return err.
//
// Ports
//   clk        system clock
//   rst        asynchronous reset, active-low
//   m_*_i      packed master request fields (dat, adr, sel, we, cyc, stb)
//   m_dat_o    read data broadcast to all masters
//   m_ack_o    ack, granted master only
//   m_err_o    err, granted master only (registered)
//   s_dat_i    packed slave read data
//   s_ack_i    slave acks
//   s_dat_o    write data, broadcast
//   s_adr_o    address, broadcast
//   s_sel_o    byte selects, broadcast
//   s_we_o     write enable, broadcast
//   s_cyc_o    cyc to the decoded slave only
//   s_stb_o    stb to the decoded slave only
//   gnt_o      one-hot current grant (debug)
//   timeout_o  one-cycle pulse when the watchdog fires
// ---------------------------------------------------------------------------
module wb_conbus_rr #(
    parameter int NUM_M    = 2,
    parameter int NUM_S    = 6,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int S_ADDR_W = 3,
    parameter logic [NUM_S*S_ADDR_W-1:0] S_MAP =
        {3'b110, 3'b101, 3'b100, 3'b011, 3'b010, 3'b000},
    parameter int TIMEOUT  = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_M*DATA_W-1:0]   m_dat_i,
    input  logic [NUM_M*ADDR_W-1:0]   m_adr_i,
    input  logic [NUM_M*DATA_W/8-1:0] m_sel_i,
    input  logic [NUM_M-1:0]          m_we_i,
    input  logic [NUM_M-1:0]          m_cyc_i,
    input  logic [NUM_M-1:0]          m_stb_i,
    output logic [DATA_W-1:0]         m_dat_o,
    output logic [NUM_M-1:0]          m_ack_o,
    output logic [NUM_M-1:0]          m_err_o,
    input  logic [NUM_S*DATA_W-1:0]   s_dat_i,
    input  logic [NUM_S-1:0]          s_ack_i,
    output logic [DATA_W-1:0]         s_dat_o,
    output logic [ADDR_W-1:0]         s_adr_o,
    output logic [DATA_W/8-1:0]       s_sel_o,
    output logic                      s_we_o,
    output logic [NUM_S-1:0]          s_cyc_o,
    output logic [NUM_S-1:0]          s_stb_o,
    output logic [NUM_M-1:0]          gnt_o,
    output logic                      timeout_o
);

    localparam int SEL_W = DATA_W / 8;
    localparam int M_IW  = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int S_IW  = (NUM_S > 1) ? $clog2(NUM_S) : 1;
    localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state;
    logic [NUM_M-1:0]  gnt;
    logic [M_IW-1:0]   gnt_idx;
    logic [M_IW-1:0]   last_gnt;
    logic [M_IW-1:0]   pick_idx;
    logic [WD_W-1:0]   wdog;
    logic [NUM_M-1:0]  err_q;
    logic              timeout_q;

    logic              busy;
    logic              g_cyc;
    logic              g_stb;
    logic              g_we;
    logic [ADDR_W-1:0] g_adr;
    logic [DATA_W-1:0] g_dat;
    logic [SEL_W-1:0]  g_sel;
    logic [S_ADDR_W-1:0] dec_tag;
    logic [NUM_S-1:0]  hit;
    logic              hit_any;
    logic [S_IW-1:0]   hit_idx;
    logic              ack_raw;

    assign busy  = (state == BUSY);
    assign g_cyc = m_cyc_i[gnt_idx];
    assign g_stb = m_stb_i[gnt_idx];
    assign g_we  = m_we_i[gnt_idx];
    assign g_adr = m_adr_i[gnt_idx*ADDR_W +: ADDR_W];
    assign g_dat = m_dat_i[gnt_idx*DATA_W +: DATA_W];
    assign g_sel = m_sel_i[gnt_idx*SEL_W +: SEL_W];

    // Round-robin pick: scan starting just after the last owner so that the
    // most recently served master has the lowest priority next time.
    always_comb begin
        int   cand;
        logic found;
        cand     = 0;
        found    = 1'b0;
        pick_idx = '0;
        for (int i = 1; i <= NUM_M; i++) begin
            cand = (int'(last_gnt) + i) % NUM_M;
            if (!found && m_cyc_i[cand]) begin
                found    = 1'b1;
                pick_idx = M_IW'(cand);
            end
        end
    end

    // Address decode; scanning from the top down lets the lowest matching
    // slot win when the map contains duplicates.
    always_comb begin
        dec_tag = g_adr[ADDR_W-1 -: S_ADDR_W];
        hit_any = 1'b0;
        hit_idx = '0;
        for (int k = NUM_S - 1; k >= 0; k--) begin
            if (S_MAP[k*S_ADDR_W +: S_ADDR_W] == dec_tag) begin
                hit_any = 1'b1;
                hit_idx = S_IW'(k);
            end
        end
        hit = hit_any ? (NUM_S'(1) << hit_idx) : '0;
    end

    // Slave-side forwarding drops with the owner's cyc in the same cycle.
    assign s_cyc_o = (busy && g_cyc) ? hit : '0;
    assign s_stb_o = (busy && g_cyc && g_stb) ? hit : '0;
    assign s_adr_o = busy ? g_adr : '0;
    assign s_dat_o = busy ? g_dat : '0;
    assign s_sel_o = busy ? g_sel : '0;
    assign s_we_o  = busy & g_we;

    // Return path. Ack is masked while a registered err is showing so the
    // master never sees both at once.
    assign ack_raw = busy & g_cyc & g_stb & hit_any & s_ack_i[hit_idx];
    assign m_ack_o = (ack_raw && !err_q[gnt_idx]) ? gnt : '0;
    assign m_dat_o = (busy && hit_any) ? s_dat_i[hit_idx*DATA_W +: DATA_W] : '0;
    assign m_err_o = err_q;
    assign timeout_o = timeout_q;
    assign gnt_o   = gnt;

    // Arbiter FSM, unmapped-err generator and watchdog. An unmapped err is
    // suppressed in the cycle it is showing, so a held stb re-errs every
    // second cycle. The watchdog only counts stalled strobes to mapped
    // slaves and loses to an ack arriving on the expiry cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_idx   <= '0;
            last_gnt  <= M_IW'(NUM_M - 1);
            wdog      <= '0;
            err_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            err_q     <= '0;
            timeout_q <= 1'b0;
            case (state)
                IDLE: begin
                    wdog <= '0;
                    if (|m_cyc_i) begin
                        gnt_idx <= pick_idx;
                        gnt     <= NUM_M'(1) << pick_idx;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (!g_cyc) begin
                        state    <= IDLE;
                        gnt      <= '0;
                        last_gnt <= gnt_idx;
                        wdog     <= '0;
                    end else if (g_stb && !hit_any && !err_q[gnt_idx]) begin
                        err_q[gnt_idx] <= 1'b1;
                        wdog           <= '0;
                    end else if (TIMEOUT != 0 && g_stb && hit_any &&
                                 !ack_raw && !err_q[gnt_idx]) begin
                        if (wdog == WD_W'(TIMEOUT - 1)) begin
                            err_q[gnt_idx] <= 1'b1;
                            timeout_q      <= 1'b1;
                            wdog           <= '0;
                        end else begin
                            wdog <= wdog + 1'b1;
                        end
                    end else begin
                        wdog <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_conbus_rr.sv
// ---------------------------------------------------------------------------
// tb_wb_conbus_rr
//   Directed bench for wb_conbus_rr with 2 masters, 6 slaves, default map
//   and a 16-cycle watchdog. Inputs change 1 time unit after the rising
//   edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_wb_conbus_rr;

    logic        clk;
    logic        rst;
    logic [63:0] m_dat_i;
    logic [63:0] m_adr_i;
    logic [7:0]  m_sel_i;
    logic [1:0]  m_we_i;
    logic [1:0]  m_cyc_i;
    logic [1:0]  m_stb_i;
    logic [31:0] m_dat_o;
    logic [1:0]  m_ack_o;
    logic [1:0]  m_err_o;
    logic [191:0] s_dat_i;
    logic [5:0]  s_ack_i;
    logic [31:0] s_dat_o;
    logic [31:0] s_adr_o;
    logic [3:0]  s_sel_o;
    logic        s_we_o;
    logic [5:0]  s_cyc_o;
    logic [5:0]  s_stb_o;
    logic [1:0]  gnt_o;
    logic        timeout_o;

    int checks;
    int errors;

    wb_conbus_rr #(
        .NUM_M   (2),
        .NUM_S   (6),
        .ADDR_W  (32),
        .DATA_W  (32),
        .S_ADDR_W(3),
        .TIMEOUT (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .m_dat_i  (m_dat_i),
        .m_adr_i  (m_adr_i),
        .m_sel_i  (m_sel_i),
        .m_we_i   (m_we_i),
        .m_cyc_i  (m_cyc_i),
        .m_stb_i  (m_stb_i),
        .m_dat_o  (m_dat_o),
        .m_ack_o  (m_ack_o),
        .m_err_o  (m_err_o),
        .s_dat_i  (s_dat_i),
        .s_ack_i  (s_ack_i),
        .s_dat_o  (s_dat_o),
        .s_adr_o  (s_adr_o),
        .s_sel_o  (s_sel_o),
        .s_we_o   (s_we_o),
        .s_cyc_o  (s_cyc_o),
        .s_stb_o  (s_stb_o),
        .gnt_o    (gnt_o),
        .timeout_o(timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input int m, input logic cyc, input logic stb,
                                 input logic we, input logic [31:0] adr,
                                 input logic [31:0] dat);
        m_cyc_i[m]           = cyc;
        m_stb_i[m]           = stb;
        m_we_i[m]            = we;
        m_adr_i[m*32 +: 32]  = adr;
        m_dat_i[m*32 +: 32]  = dat;
        m_sel_i[m*4 +: 4]    = cyc ? 4'hF : 4'h0;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b0;
        m_dat_i = '0;
        m_adr_i = '0;
        m_sel_i = '0;
        m_we_i  = '0;
        m_cyc_i = '0;
        m_stb_i = '0;
        s_dat_i = '0;
        s_ack_i = '0;

        // Reset state
        #12;
        checkOutput("rst_gnt", 64'(gnt_o), 64'h0);
        checkOutput("rst_s_cyc", 64'(s_cyc_o), 64'h0);
        checkOutput("rst_m_ack", 64'(m_ack_o), 64'h0);
        checkOutput("rst_m_err", 64'(m_err_o), 64'h0);
        checkOutput("rst_timeout", 64'(timeout_o), 64'h0);
        rst = 1'b1;
        step();

        // M0 read to slot1 (tag 3'b010), ack after 2 cycles
        $display("[TB] M0 read slot1");
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h4000_0004, 32'h0);
        settle();
        checkOutput("idle_no_s_cyc", 64'(s_cyc_o), 64'h0);
        checkOutput("idle_no_gnt", 64'(gnt_o), 64'h0);
        step();
        settle();
        checkOutput("rd_gnt", 64'(gnt_o), 64'h1);
        checkOutput("rd_s_cyc", 64'(s_cyc_o), 64'h02);
        checkOutput("rd_s_stb", 64'(s_stb_o), 64'h02);
        checkOutput("rd_s_adr", 64'(s_adr_o), 64'h4000_0004);
        checkOutput("rd_no_ack_yet", 64'(m_ack_o), 64'h0);
        step();
        step();
        s_dat_i[1*32 +: 32] = 32'h1234_5678;
        s_ack_i = 6'b000010;
        settle();
        checkOutput("rd_m_ack", 64'(m_ack_o), 64'h1);
        checkOutput("rd_m_dat", 64'(m_dat_o), 64'h1234_5678);
        checkOutput("rd_m_err", 64'(m_err_o), 64'h0);
        step();
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        s_ack_i = '0;
        settle();
        checkOutput("rd_drop_s_cyc", 64'(s_cyc_o), 64'h0);
        step();
        settle();
        checkOutput("rd_back_idle", 64'(gnt_o), 64'h0);

        // Round-robin after a fresh reset
        $display("[TB] round robin");
        rst = 1'b0;
        #2;
        rst = 1'b1;
        step();
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        settle();
        checkOutput("rr_first_m0", 64'(gnt_o), 64'h1);
        step();
        step();
        settle();
        checkOutput("rr_m0_held", 64'(gnt_o), 64'h1);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        settle();
        checkOutput("rr_idle_gap1", 64'(gnt_o), 64'h0);
        step();
        settle();
        checkOutput("rr_then_m1", 64'(gnt_o), 64'h2);
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        step();
        settle();
        checkOutput("rr_m1_held", 64'(gnt_o), 64'h2);
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        settle();
        checkOutput("rr_idle_gap2", 64'(gnt_o), 64'h0);
        step();
        settle();
        checkOutput("rr_back_m0", 64'(gnt_o), 64'h1);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        settle();

        // M1 write to an unmapped tag (3'b111)
        $display("[TB] M1 unmapped write");
        applyStimulus(1, 1'b1, 1'b1, 1'b1, 32'hE000_0000, 32'hCAFE_F00D);
        step();
        settle();
        checkOutput("um_gnt", 64'(gnt_o), 64'h2);
        checkOutput("um_s_cyc", 64'(s_cyc_o), 64'h0);
        checkOutput("um_s_we", 64'(s_we_o), 64'h1);
        checkOutput("um_s_dat", 64'(s_dat_o), 64'hCAFE_F00D);
        checkOutput("um_err_not_yet", 64'(m_err_o), 64'h0);
        step();
        settle();
        checkOutput("um_err", 64'(m_err_o), 64'h2);
        checkOutput("um_no_ack", 64'(m_ack_o), 64'h0);
        step();
        settle();
        checkOutput("um_err_gap", 64'(m_err_o), 64'h0);
        step();
        settle();
        checkOutput("um_err_again", 64'(m_err_o), 64'h2);
        checkOutput("um_s_cyc_still0", 64'(s_cyc_o), 64'h0);
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        settle();
        checkOutput("um_done_err", 64'(m_err_o), 64'h0);

        // Watchdog: slot3 (tag 3'b100) never acks
        $display("[TB] watchdog expiry");
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h8000_0000, 32'h0);
        step();
        repeat (15) step();
        settle();
        checkOutput("wd_s_cyc", 64'(s_cyc_o), 64'h08);
        checkOutput("wd_pre_err", 64'(m_err_o), 64'h0);
        checkOutput("wd_pre_timeout", 64'(timeout_o), 64'h0);
        step();
        settle();
        checkOutput("wd_err", 64'(m_err_o), 64'h1);
        checkOutput("wd_timeout", 64'(timeout_o), 64'h1);
        step();
        settle();
        checkOutput("wd_err_pulse", 64'(m_err_o), 64'h0);
        checkOutput("wd_timeout_pulse", 64'(timeout_o), 64'h0);
        repeat (15) step();
        settle();
        checkOutput("wd_restart_quiet", 64'(m_err_o), 64'h0);
        step();
        settle();
        checkOutput("wd_restart_err", 64'(m_err_o), 64'h1);
        checkOutput("wd_restart_timeout", 64'(timeout_o), 64'h1);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        step();

        // Ack arriving exactly on the expiry cycle wins
        $display("[TB] ack on expiry");
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h8000_0000, 32'h0);
        step();
        repeat (15) step();
        s_dat_i[3*32 +: 32] = 32'hA5A5_A5A5;
        s_ack_i = 6'b001000;
        settle();
        checkOutput("aw_ack", 64'(m_ack_o), 64'h1);
        checkOutput("aw_dat", 64'(m_dat_o), 64'hA5A5_A5A5);
        step();
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        s_ack_i = '0;
        settle();
        checkOutput("aw_no_err", 64'(m_err_o), 64'h0);
        checkOutput("aw_no_timeout", 64'(timeout_o), 64'h0);
        step();
        step();

        // Reset during an M0 burst to slot0; M1 also waiting
        $display("[TB] reset mid-burst");
        applyStimulus(0, 1'b1, 1'b1, 1'b1, 32'h0000_0010, 32'h1111_1111);
        s_ack_i = 6'b000001;
        step();
        settle();
        checkOutput("br_s_cyc", 64'(s_cyc_o), 64'h01);
        checkOutput("br_ack", 64'(m_ack_o), 64'h1);
        applyStimulus(1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        #2;
        rst = 1'b0;
        #1;
        checkOutput("br_rst_gnt", 64'(gnt_o), 64'h0);
        checkOutput("br_rst_s_cyc", 64'(s_cyc_o), 64'h0);
        checkOutput("br_rst_s_stb", 64'(s_stb_o), 64'h0);
        checkOutput("br_rst_ack", 64'(m_ack_o), 64'h0);
        checkOutput("br_rst_adr", 64'(s_adr_o), 64'h0);
        checkOutput("br_rst_we", 64'(s_we_o), 64'h0);
        #1;
        rst = 1'b1;
        step();
        settle();
        checkOutput("br_regrant_m0", 64'(gnt_o), 64'h1);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        s_ack_i = '0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
